tc_c_cn: RTL and testbench

//  Collection network for the tensor-core output path; the reverse direction of the B-operand distribution network.

---
 rtl/tc_c_cn.sv | 88 ++++++++
 tb/tb_tc_c_cn.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/tc_c_cn.sv
// tc_c_cn: tensor-core C collection network; accumulates STEP partial slices per tile
// from all PEs, then drains the tile one PE row per handshake toward the C buffer.
module tc_c_cn #(
    parameter int NUM_TILE = 16,
    parameter int DW_DATA  = 16,
    parameter int DW_ACC   = 32,
    parameter int N_PE     = 4,
    parameter int STEP     = 4,
    localparam int IW = (N_PE > 1) ? $clog2(N_PE) : 1,
    localparam int SW = $clog2(STEP + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_PE*NUM_TILE*DW_DATA-1:0] in_c,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_TILE*DW_ACC-1:0]    out_c,
    output logic [IW-1:0]                 out_pe_idx,
    output logic                          out_last,
    output logic                          busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
    state_t state;
    logic [SW-1:0] step_cnt;
    logic [IW-1:0] drain_idx;
    logic signed [DW_ACC-1:0] acc [N_PE][NUM_TILE];
    logic acc_en, clear;
    assign acc_en     = in_valid && state != DRAIN;
    assign clear      = state == IDLE;
    assign in_ready   = state != DRAIN;
    assign out_valid  = state == DRAIN;
    assign out_pe_idx = drain_idx;
    assign out_last   = state == DRAIN && drain_idx == IW'(N_PE - 1);
    assign busy       = state != IDLE;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            step_cnt  <= '0;
            drain_idx <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    step_cnt  <= (STEP == 1) ? '0 : SW'(1);
                    drain_idx <= '0;
                    state     <= (STEP == 1) ? DRAIN : ACCUM;
                end
                ACCUM: if (in_valid) begin
                    if (step_cnt == SW'(STEP - 1)) begin
                        step_cnt  <= '0;
                        drain_idx <= '0;
                        state     <= DRAIN;
                    end else begin
                        step_cnt <= step_cnt + SW'(1);
                    end
                end
                DRAIN: if (out_ready) begin
                    if (drain_idx == IW'(N_PE - 1)) begin
                        drain_idx <= '0;
                        state     <= IDLE;
                    end else begin
                        drain_idx <= drain_idx + IW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    // First slice of a tile overwrites, later slices add; sums wrap at DW_ACC bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < N_PE; p++)
                for (int t = 0; t < NUM_TILE; t++)
                    acc[p][t] <= '0;
        end else if (acc_en) begin
            for (int p = 0; p < N_PE; p++)
                for (int t = 0; t < NUM_TILE; t++)
                    acc[p][t] <= (clear ? '0 : acc[p][t])
                               + DW_ACC'($signed(in_c[(p*NUM_TILE+t)*DW_DATA +: DW_DATA]));
        end
    end
    always_comb begin
        out_c = '0;
        for (int t = 0; t < NUM_TILE; t++)
            out_c[t*DW_ACC +: DW_ACC] = (state == DRAIN) ? acc[drain_idx][t] : '0;
    end
endmodule

// File: tb/tb_tc_c_cn.sv
// tb_tc_c_cn: directed, table-driven bench for the tensor-core C collection network.
module tb_tc_c_cn;
    localparam int NT = 16, DD = 16, DA = 32, NP = 4, ST = 4;
    logic clk = 0, reset = 0, in_valid = 0, out_ready = 1;
    logic in_ready, out_valid, out_last, busy;
    logic [NP*NT*DD-1:0] in_c = '0;
    logic [NT*DA-1:0] out_c;
    logic [1:0] out_pe_idx;
    int checks = 0, failures = 0;

    tc_c_cn #(.NUM_TILE(NT), .DW_DATA(DD), .DW_ACC(DA), .N_PE(NP), .STEP(ST)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_c(in_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
        .out_pe_idx(out_pe_idx), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          mode;
        logic [15:0] val;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // mode 0: ramp element (p,t) = p*16+t; mode 1: every element = v
    function automatic logic [NP*NT*DD-1:0] mk_slice(int mode, logic [15:0] v);
        logic [NP*NT*DD-1:0] s;
        for (int p = 0; p < NP; p++)
            for (int t = 0; t < NT; t++)
                s[(p*NT+t)*DD +: DD] = (mode == 0) ? 16'(p*16 + t) : v;
        return s;
    endfunction

    function automatic logic [NT*DA-1:0] mk_row(int mode, logic [31:0] e, int p);
        logic [NT*DA-1:0] r;
        for (int t = 0; t < NT; t++)
            r[t*DA +: DA] = (mode == 0) ? 32'(4 * (p*16 + t)) : e;
        return r;
    endfunction

    task automatic feed(string name, int mode, logic [15:0] v, int n);
        for (int s = 0; s < n; s++) begin
            in_valid = 1;
            in_c = mk_slice(mode, v);
            chk({name, "_in_ready"}, 512'(in_ready), 512'(1));
            tick();
        end
        in_valid = 0;
    endtask

    task automatic drain(string name, int mode, logic [31:0] e);
        out_ready = 1;
        for (int r = 0; r < NP; r++) begin
            chk({name, "_valid"}, 512'(out_valid), 512'(1));
            chk({name, "_idx"}, 512'(out_pe_idx), 512'(r));
            chk({name, "_last"}, 512'(out_last), 512'(r == NP - 1));
            chk({name, "_row"}, 512'(out_c), mk_row(mode, e, r));
            tick();
        end
        chk({name, "_done_valid"}, 512'(out_valid), 512'(0));
        chk({name, "_done_busy"}, 512'(busy), 512'(0));
    endtask

    task automatic pulse_reset(string name);
        reset = 0;
        #2;
        chk({name, "_valid"}, 512'(out_valid), 512'(0));
        chk({name, "_busy"}, 512'(busy), 512'(0));
        chk({name, "_in_ready"}, 512'(in_ready), 512'(1));
        chk({name, "_out_c"}, 512'(out_c), 512'(0));
        reset = 1;
    endtask

    initial begin
        logic [511:0] held;
        logic [6:0] gap_pat;
        tbl[0] = '{"ramp",   0, 16'h0000, 32'h0};
        tbl[1] = '{"neg1",   1, 16'hFFFF, 32'hFFFFFFFC};
        tbl[2] = '{"minneg", 1, 16'h8000, 32'hFFFE0000};
        tbl[3] = '{"ones",   1, 16'h0001, 32'h00000004};
        tbl[4] = '{"maxpos", 1, 16'h7FFF, 32'h0001FFFC};
        tbl[5] = '{"zero",   1, 16'h0000, 32'h00000000};

        #3;
        chk("rst_in_ready", 512'(in_ready), 512'(1));
        chk("rst_valid", 512'(out_valid), 512'(0));
        chk("rst_last", 512'(out_last), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_idx", 512'(out_pe_idx), 512'(0));
        chk("rst_out_c", 512'(out_c), 512'(0));
        tick();
        reset = 1;
        tick();

        for (int i = 0; i < 6; i++) begin
            feed(tbl[i].name, tbl[i].mode, tbl[i].val, ST);
            drain(tbl[i].name, tbl[i].mode, tbl[i].exp);
        end

        // Backpressure on row 2 for three cycles
        feed("bp", 0, 16'h0, ST);
        out_ready = 1;
        tick();
        tick();
        chk("bp_idx2", 512'(out_pe_idx), 512'(2));
        held = out_c;
        out_ready = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_hold_valid", 512'(out_valid), 512'(1));
            chk("bp_hold_idx", 512'(out_pe_idx), 512'(2));
            chk("bp_hold_row", out_c, held);
            chk("bp_hold_row_exp", out_c, mk_row(0, 0, 2));
        end
        out_ready = 1;
        tick();
        chk("bp_next_idx", 512'(out_pe_idx), 512'(3));
        chk("bp_next_last", 512'(out_last), 512'(1));
        chk("bp_next_row", out_c, mk_row(0, 0, 3));
        tick();
        chk("bp_done", 512'(out_valid), 512'(0));

        // Input gaps: 1,0,0,1,1,0,1
        gap_pat = 7'b1011001;
        in_c = mk_slice(0, 16'h0);
        for (int c = 0; c < 7; c++) begin
            in_valid = gap_pat[c];
            chk("gap_out_valid_pre", 512'(out_valid), 512'(0));
            tick();
        end
        in_valid = 0;
        drain("gap", 0, 32'h0);

        // Back-to-back: next tile waits during DRAIN, accepted right after last emit
        feed("b2b_a", 0, 16'h0, ST);
        in_valid = 1;
        in_c = mk_slice(1, 16'h0001);
        for (int r = 0; r < NP; r++) begin
            chk("b2b_in_ready_drain", 512'(in_ready), 512'(0));
            chk("b2b_row_a", out_c, mk_row(0, 0, r));
            tick();
        end
        chk("b2b_idle_ready", 512'(in_ready), 512'(1));
        feed("b2b_b", 1, 16'h0001, ST);
        drain("b2b_b", 1, 32'h4);

        // Reset mid-ACCUM then mid-DRAIN
        feed("rma", 0, 16'h0, 2);
        chk("rma_busy_pre", 512'(busy), 512'(1));
        pulse_reset("rma");
        tick();
        chk("rma_after_valid", 512'(out_valid), 512'(0));
        feed("rma_clean", 1, 16'h0001, ST);
        drain("rma_clean", 1, 32'h4);
        feed("rmd", 0, 16'h0, ST);
        tick();
        chk("rmd_idx1", 512'(out_pe_idx), 512'(1));
        pulse_reset("rmd");
        tick();
        chk("rmd_after_valid", 512'(out_valid), 512'(0));
        feed("rmd_clean", 1, 16'hFFFF, ST);
        drain("rmd_clean", 1, 32'hFFFFFFFC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
